// File: rtl/addsub_digit_serial.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per cycle, registered carry chain.
// Optional build macro ADDSUB_SAT_EN saturates the result on signed overflow.
module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("addsub_digit_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_eff;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_chain;
    logic             r_carry;
    logic             r_overflow;
    logic [CW-1:0]    r_count;

    logic [DIGIT-1:0] w_a_slice [NSLICE];
    logic [DIGIT-1:0] w_b_slice [NSLICE];
    logic [DIGIT:0]   w_sum;
    logic             w_last;
    logic             w_accept;
    logic             w_release;
    logic             w_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign w_a_slice[gi] = r_a[gi*DIGIT +: DIGIT];
            assign w_b_slice[gi] = r_b_eff[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_last    = (r_count == LAST_SLICE);
    assign w_sum     = {1'b0, w_a_slice[r_count]} + {1'b0, w_b_slice[r_count]}
                     + {{DIGIT{1'b0}}, r_carry_chain};
    // On the last slice the sum MSB is the result sign bit.
    assign w_overflow = (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) && (w_sum[DIGIT-1] != r_a[WIDTH-1]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (w_release) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result      <= '0;
            r_carry       <= 1'b0;
            r_overflow    <= 1'b0;
            r_count       <= '0;
            r_carry_chain <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a           <= a;
                        r_b_eff       <= sub ? ~b : b;
                        r_carry_chain <= sub;
                        r_count       <= '0;
                    end
                end
                ST_RUN: begin
                    r_result[r_count*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
                    r_carry_chain <= w_sum[DIGIT];
                    r_count       <= w_last ? '0 : r_count + 1'b1;
                    if (w_last) begin
                        r_carry    <= w_sum[DIGIT];
                        r_overflow <= w_overflow;
`ifdef ADDSUB_SAT_EN
                        if (w_overflow) begin
                            r_result <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Directed bench for addsub_digit_serial: a DIGIT=4 unit and a DIGIT=16 unit share clock and reset.
module tb_addsub_digit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry, overflow;
    logic [15:0] a, b, result;
    logic        in_valid_w, in_ready_w, sub_w, out_valid_w, out_ready_w, carry_w, overflow_w;
    logic [15:0] a_w, b_w, result_w;

    int tests_run    = 0;
    int tests_failed = 0;

    addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow)
    );

    addsub_digit_serial #(.WIDTH(16), .DIGIT(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .sub(sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .carry(carry_w), .overflow(overflow_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent integer reference used for the wide unit.
    task automatic ref_model(input logic [15:0] x, input logic [15:0] y, input logic s,
                             output logic [15:0] r, output logic c, output logic o);
        int sx, sy, sr;
        logic [16:0] full;
        sx = $signed(x);
        sy = $signed(y);
        if (!s) begin
            full = {1'b0, x} + {1'b0, y};
            c    = full[16];
            sr   = sx + sy;
        end else begin
            full = {1'b0, x} - {1'b0, y};
            c    = (x >= y);
            sr   = sx - sy;
        end
        r = full[15:0];
        o = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
        if (o) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (in_ready) seen = 1;
        end
        check({tag, "_ready"}, 32'(seen), 32'd1);
    endtask

    // Accept an op on the narrow unit and return the edge count until out_valid.
    task automatic start_and_wait(input string tag, input logic [15:0] x, input logic [15:0] y,
                                  input logic s, output int lat);
        bit seen = 0;
        wait_ready(tag);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'(($urandom)); b = 16'(($urandom)); sub = ~s;
        lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic [15:0] er, input logic ec, input logic eo);
        int lat;
        start_and_wait(tag, x, y, s, lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
        $display("[TB] %s a=%04h b=%04h sub=%0d -> result=%04h carry=%0d ovf=%0d lat=%0d",
                 tag, x, y, s, result, carry, overflow, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_inrdy_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op_w(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic s);
        logic [15:0] er;
        logic ec, eo;
        bit seen = 0;
        bit rdy = 0;
        int lat = 0;
        ref_model(x, y, s, er, ec, eo);
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk);
            if (in_ready_w) rdy = 1;
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        a_w = x; b_w = y; sub_w = s; in_valid_w = 1'b1;
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid_w) seen = 1;
        end
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_result"}, 32'(result_w), 32'(er));
        check({tag, "_carry"}, 32'(carry_w), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow_w), 32'(eo));
        $display("[TB] %s a=%04h b=%04h sub=%0d -> result=%04h carry=%0d ovf=%0d lat=%0d",
                 tag, x, y, s, result_w, carry_w, overflow_w, lat);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int stray;
        logic [15:0] sat_pos, sat_neg;
`ifdef ADDSUB_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'h8000;
        sat_neg = 16'h7FFF;
`endif
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 0;
        in_valid_w = 0; a_w = 0; b_w = 0; sub_w = 0; out_ready_w = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_inrdy_held", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_inrdy", 32'(in_ready), 32'd1);
        check("reset_outvalid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_w_inrdy", 32'(in_ready_w), 32'd1);

        run_op("add_basic",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, sat_pos,  1'b0, 1'b1);
        run_op("sub_borrow",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, sat_neg,  1'b1, 1'b1);
        run_op("sub_equal",   16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Hold the result in DONE while in_valid toggles.
        start_and_wait("hold", 16'h1111, 16'h2222, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            check("hold_result", 32'(result), 32'h3333);
            check("hold_flags", {30'd0, carry, overflow}, 32'd0);
            check("hold_inrdy", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
            in_valid = i[0];
            a = 16'(($urandom)); b = 16'(($urandom)); sub = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("hold_no_extra_op", 32'(stray), 32'd0);
        check("hold_inrdy_after", 32'(in_ready), 32'd1);
        $display("[TB] hold: result stable for 10 stalled cycles");

        // Abort an op with reset after two slices.
        wait_ready("abort");
        a = 16'h4444; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_inrdy", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("abort_no_valid", 32'(stray), 32'd0);
        $display("[TB] abort: op dropped by reset after two slices");
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Single-slice unit against the reference model.
        run_op_w("w_add_basic", 16'h1234, 16'h0FFF, 1'b0);
        run_op_w("w_add_ovf",   16'h7FFF, 16'h0001, 1'b0);
        run_op_w("w_sub_ovf",   16'h8000, 16'h0001, 1'b1);
        run_op_w("w_sub_min",   16'h0000, 16'h8000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_op_w("w_rand", 16'(($urandom)), 16'(($urandom)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
